// File: rtl/rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_arbiter_pkg
// Brief    : Shared types and constants for the instruction-memory arbiter:
//            bus widths, FSM state encodings and master identifiers.
// Revision : 1.0 - initial release
// ============================================================================
package rom_arbiter_pkg;

    // Default bus width (RegBus) for addresses and data
    localparam int ARB_REG_BUS     = 32;
    // Default memory read latency: 1 = registered-output memory
    localparam int ARB_RD_LAT_DEF  = 1;

    // Arbiter FSM states, explicitly encoded
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD0  = 2'd1,
        ARB_RD1  = 2'd2
    } arb_state_t;

    // Master identifiers; also the value of the round-robin pointer
    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rom_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter. Combinational one-hot grant from the
//            request vector; the pointer names the master that wins a tie and
//            moves to the other master whenever a grant is taken (advance).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import rom_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic r_ptr;

    // Single requester wins outright; a tie goes to the pointer's master
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (r_ptr == ARB_M0) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer moves to the master that did not receive the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= ARB_M0;
        end else if (advance) begin
            r_ptr <= gnt[0] ? ARB_M1 : ARB_M0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_arbiter
// Brief    : Shares a single-port instruction memory between the core fetch
//            port (m0, read-only) and a loader/debug port (m1, read/write).
//            Round-robin grant in IDLE only, one read in flight, registered
//            per-master read response. Writes complete in the grant cycle.
// Options  : ROM_ARB_WLOCK_EN - adds wlock input and sticky wr_err output;
//            m1 writes granted under wlock are acknowledged but dropped.
// Revision : 1.0 - initial release
// ============================================================================
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int AW     = ARB_REG_BUS,
    parameter int DW     = ARB_REG_BUS,
    parameter int RD_LAT = ARB_RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_w_addr,
    output logic [DW-1:0] mem_w_data,
    output logic          mem_ren,
    output logic [AW-1:0] mem_r_addr,
    input  logic [DW-1:0] mem_r_data,
`ifdef ROM_ARB_WLOCK_EN
    input  logic          wlock,
    output logic          wr_err,
`endif
    output logic          busy
);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;

    logic [1:0]    w_arb_req;
    logic [1:0]    w_gnt;
    logic          w_can_grant;
    logic          w_any_gnt;
    logic          w_gnt_id;
    logic [AW-1:0] w_gnt_addr;
    logic          w_is_wr;
    logic          w_is_rd;
    logic          w_wr_block;
    logic          w_capture;
    logic          w_cap_id;

    logic          r_rsp_id;
    logic [AW-1:0] r_rsp_addr;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;

    // Requests only reach the arbiter when idle and out of reset, so no
    // grant (and no pointer movement) can happen while a read is pending.
    assign w_can_grant = (r_state == ARB_IDLE) && !rst;
    assign w_arb_req   = {m1_req, m0_req} & {2{w_can_grant}};

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     (w_arb_req),
        .advance (w_any_gnt),
        .gnt     (w_gnt)
    );

    assign w_any_gnt  = |w_gnt;
    assign w_gnt_id   = w_gnt[1];
    assign w_gnt_addr = w_gnt[1] ? m1_addr : m0_addr;
    assign w_is_wr    = w_gnt[1] & m1_we;
    assign w_is_rd    = w_any_gnt & ~w_is_wr;

    assign m0_gnt     = w_gnt[0];
    assign m1_gnt     = w_gnt[1];

    // Write path: only m1 writes, and it completes in the grant cycle
    assign mem_wen    = w_is_wr & ~w_wr_block;
    assign mem_w_addr = m1_addr;
    assign mem_w_data = m1_wdata;

    assign busy       = (r_state != ARB_IDLE);
    assign m0_rdata   = r_m0_rdata;
    assign m1_rdata   = r_m1_rdata;

`ifdef ROM_ARB_WLOCK_EN
    logic r_wr_err;

    assign w_wr_block = wlock;
    assign wr_err     = r_wr_err;

    // Sticky flag: any write attempted under lock, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else if (w_is_wr && wlock) begin
            r_wr_err <= 1'b1;
        end
    end
`else
    assign w_wr_block = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, read-port drive, capture strobe and rvalid decode
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_cap_id    = r_rsp_id;
        mem_ren     = 1'b0;
        mem_r_addr  = w_gnt_addr;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_is_rd) begin
                    mem_ren = 1'b1;
                    if (RD_LAT == 0) begin
                        // Combinational memory: data is valid at the grant edge
                        w_capture   = 1'b1;
                        w_cap_id    = w_gnt_id;
                        w_state_nxt = ARB_RD0;
                    end else begin
                        w_state_nxt = ARB_RD1;
                    end
                end
            end
            ARB_RD1: begin
                // Hold the read request one more cycle for the registered memory
                mem_ren     = 1'b1;
                mem_r_addr  = r_rsp_addr;
                w_capture   = 1'b1;
                w_state_nxt = ARB_RD0;
            end
            ARB_RD0: begin
                m0_rvalid   = (r_rsp_id == ARB_M0);
                m1_rvalid   = (r_rsp_id == ARB_M1);
                w_state_nxt = ARB_IDLE;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
        // A response pending at reset is discarded, never presented
        if (rst) begin
            mem_ren   = 1'b0;
            m0_rvalid = 1'b0;
            m1_rvalid = 1'b0;
        end
    end

    // Response register: owner/address at grant, data into the owner's slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_id   <= ARB_M0;
            r_rsp_addr <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            if (w_is_rd) begin
                r_rsp_id   <= w_gnt_id;
                r_rsp_addr <= w_gnt_addr;
            end
            if (w_capture) begin
                if (w_cap_id == ARB_M1) begin
                    r_m1_rdata <= mem_r_data;
                end else begin
                    r_m0_rdata <= mem_r_data;
                end
            end
        end
    end

endmodule
`default_nettype wire
